// File: rtl/matmul_mac_engine_if.sv
// Bus bundle between the MAC engine, its A/B/C memories and the state controller.
interface matmul_mac_engine_if #(
  parameter int N      = 4,
  parameter int DATA_W = 8,
  parameter int AW     = $clog2(N*N),
  parameter int ACC_W  = 2*DATA_W + $clog2(N)
);
  logic [1:0]               status;
  logic [AW-1:0]            a_addr;
  logic [AW-1:0]            b_addr;
  logic signed [DATA_W-1:0] a_data;
  logic signed [DATA_W-1:0] b_data;
  logic                     c_we;
  logic [AW-1:0]            c_addr;
  logic signed [ACC_W-1:0]  c_data;
  logic                     busy;
  logic                     process_finish;

  // engine side
  modport master (
    input  status, a_data, b_data,
    output a_addr, b_addr, c_we, c_addr, c_data, busy, process_finish
  );

  // controller / memory side
  modport slave (
    output status, a_data, b_data,
    input  a_addr, b_addr, c_we, c_addr, c_data, busy, process_finish
  );
endinterface

// File: rtl/matmul_mac_engine.sv
// C = A x B sequencer: one MAC per cycle, k innermost, three-stage
// issue / accumulate / write pipeline behind synchronous-read memories.
module matmul_mac_engine #(
  parameter int N      = 4,
  parameter int DATA_W = 8,
  parameter int AW     = $clog2(N*N),
  parameter int ACC_W  = 2*DATA_W + $clog2(N)
) (
  input  logic                 clock,
  input  logic                 reset,
  matmul_mac_engine_if.master  bus
);
  localparam int LW = $clog2(N);
  localparam logic [LW-1:0] MAXI = LW'(N-1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  // per-issue tag travelling alongside the memory read
  typedef struct packed {
    logic          first;
    logic          last;
    logic [LW-1:0] i;
    logic [LW-1:0] j;
  } tag_t;

  state_t state_q, state_d;
  logic   drain_q;
  logic   start, adv, abort, issue_last;
  logic   busy, finish;

  logic [LW-1:0] i_q, j_q, k_q;
  logic [LW-1:0] i_n, j_n, k_n;
  logic [AW-1:0] a_addr_q, b_addr_q, c_addr_q;
  logic [1:0]    vld_pipe_q;
  tag_t          tag0_q, tag1_q;

  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    acc_q, acc_d, c_data_q;
  logic                       c_we_q, wr_d;

  // sequencing decisions shared by FSM and datapath
  always_comb begin
    issue_last = (i_q == MAXI) && (j_q == MAXI) && (k_q == MAXI);
    start      = (state_q == IDLE) && (bus.status == 2'b01);
    adv        = (state_q == RUN) && (bus.status == 2'b01) && !issue_last;
    abort      = ((state_q == RUN) || (state_q == DRAIN)) && (bus.status != 2'b01);
  end

  // state register; drain_q counts the two drain cycles
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      drain_q <= 1'b0;
    end else begin
      state_q <= state_d;
      drain_q <= (state_q == DRAIN) && !drain_q;
    end
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (bus.status == 2'b01) state_d = RUN;
      RUN:   if (bus.status != 2'b01) state_d = IDLE;
             else if (issue_last)     state_d = DRAIN;
      DRAIN: if (bus.status != 2'b01) state_d = IDLE;
             else if (drain_q)        state_d = DONE;
      DONE:  if (bus.status == 2'b00) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // state-decoded outputs
  always_comb begin
    busy   = (state_q == RUN) || (state_q == DRAIN);
    finish = (state_q == DONE);
  end

  // next (i,j,k): k innermost, wraps carry into j then i; start restarts at 0
  always_comb begin
    k_n = k_q + 1'b1;
    j_n = j_q;
    i_n = i_q;
    if (k_q == MAXI) begin
      j_n = j_q + 1'b1;
      if (j_q == MAXI) i_n = i_q + 1'b1;
    end
    if (start) begin
      i_n = '0;
      j_n = '0;
      k_n = '0;
    end
  end

  // stage-1 MAC and stage-2 write decision
  always_comb begin
    prod  = bus.a_data * bus.b_data;
    acc_d = (tag1_q.first ? '0 : acc_q)
          + {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
    wr_d  = vld_pipe_q[1] && tag1_q.last && !abort;
  end

  // issue / accumulate / write pipeline; abort kills everything in flight
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      i_q        <= '0;
      j_q        <= '0;
      k_q        <= '0;
      a_addr_q   <= '0;
      b_addr_q   <= '0;
      vld_pipe_q <= '0;
      tag0_q     <= '0;
      tag1_q     <= '0;
      acc_q      <= '0;
      c_we_q     <= 1'b0;
      c_addr_q   <= '0;
      c_data_q   <= '0;
    end else begin
      vld_pipe_q[1] <= vld_pipe_q[0] && !abort;
      tag1_q        <= tag0_q;
      if (start || adv) begin
        i_q           <= i_n;
        j_q           <= j_n;
        k_q           <= k_n;
        a_addr_q      <= AW'({i_n, k_n});
        b_addr_q      <= AW'({k_n, j_n});
        vld_pipe_q[0] <= 1'b1;
        tag0_q        <= '{first: (k_n == '0), last: (k_n == MAXI), i: i_n, j: j_n};
      end else begin
        vld_pipe_q[0] <= 1'b0;
      end
      if (vld_pipe_q[1]) acc_q <= acc_d;
      c_we_q <= wr_d;
      if (wr_d) begin
        c_addr_q <= AW'({tag1_q.i, tag1_q.j});
        c_data_q <= acc_d;
      end
    end
  end

  assign bus.a_addr         = a_addr_q;
  assign bus.b_addr         = b_addr_q;
  assign bus.c_we           = c_we_q;
  assign bus.c_addr         = c_addr_q;
  assign bus.c_data         = c_data_q;
  assign bus.busy           = busy;
  assign bus.process_finish = finish;
endmodule

// File: tb/tb_matmul_mac_engine.sv
// Directed bench for matmul_mac_engine (N=2): matrix-product model plus
// cycle-exact schedule checks, with literal expectations for each case.
module tb_matmul_mac_engine;
  localparam int N = 2, DW = 8, AW = 2, ACC_W = 17;
  localparam int NN = N*N, N3 = N*N*N;
  localparam int M_OFF = 0, M_IDLE = 1, M_RUN = 2, M_QUIET = 3;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  matmul_mac_engine_if #(.N(N), .DATA_W(DW), .AW(AW), .ACC_W(ACC_W)) bus();

  matmul_mac_engine #(.N(N), .DATA_W(DW), .AW(AW), .ACC_W(ACC_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.master)
  );

  logic signed [DW-1:0] amem [NN];
  logic signed [DW-1:0] bmem [NN];
  int av [NN], bv [NN], cexp [NN], cwr [NN];
  int vectors = 0, miscompares = 0;
  int rc, nwr, mode;
  int ck_e, ck_i, ck_j, ck_k;
  bit ck_we;
  logic [ACC_W-1:0] raw;

  // synchronous-read memories, one cycle latency
  always @(posedge clock) begin
    bus.a_data <= amem[bus.a_addr];
    bus.b_data <= bmem[bus.b_addr];
  end

  task automatic chk(input string name, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // C[i][j] = sum_k A[i][k]*B[k][j]
  task automatic model();
    for (int e = 0; e < NN; e++) begin
      int s;
      s = 0;
      for (int k = 0; k < N; k++) s += av[(e/N)*N + k] * bv[k*N + (e%N)];
      cexp[e] = s;
    end
  endtask

  // per-cycle compare against the schedule: write of element e at cycle e*N+N+1
  always @(negedge clock) begin
    case (mode)
      M_IDLE: begin
        chk("idle_c_we", bus.c_we, 0);
        chk("idle_busy", bus.busy, 0);
        chk("idle_finish", bus.process_finish, 0);
        chk("idle_a_addr", bus.a_addr, 0);
        chk("idle_b_addr", bus.b_addr, 0);
      end
      M_QUIET: begin
        chk("quiet_c_we", bus.c_we, 0);
        chk("quiet_busy", bus.busy, 0);
        chk("quiet_finish", bus.process_finish, 0);
      end
      M_RUN: begin
        rc++;
        if (rc >= 0) begin
          ck_we = (rc >= N+1) && ((rc-N-1) % N == 0) && ((rc-N-1)/N < NN);
          chk("run_c_we", bus.c_we, ck_we);
          chk("run_busy", bus.busy, rc <= N3+1);
          chk("run_finish", bus.process_finish, rc >= N3+2);
          if (ck_we) begin
            ck_e = (rc-N-1)/N;
            chk("run_c_addr", bus.c_addr, ck_e);
            chk("run_c_data", $signed(bus.c_data), cexp[ck_e]);
            cwr[ck_e] = int'($signed(bus.c_data));
          end
          if (bus.c_we) nwr++;
          if (rc < N3) begin
            ck_i = rc / NN;
            ck_j = (rc / N) % N;
            ck_k = rc % N;
            chk("run_a_addr", bus.a_addr, ck_i*N + ck_k);
            chk("run_b_addr", bus.b_addr, ck_k*N + ck_j);
          end
        end
      end
      default: ;
    endcase
  end

  task automatic start_run();
    for (int e = 0; e < NN; e++) begin
      amem[e] = av[e][DW-1:0];
      bmem[e] = bv[e][DW-1:0];
      cwr[e]  = -999999;
    end
    model();
    @(posedge clock); #1;
    nwr = 0;
    rc = -2;
    mode = M_RUN;
    bus.status = 2'b01;
  endtask

  task automatic do_run();
    start_run();
    repeat (N3+5) @(posedge clock);
    #1;
    mode = M_OFF;
    chk("write_count", nwr, NN);
  endtask

  // pins both the model and the captured DUT writes to hand-computed values
  task automatic chk_c(input string name, input int c0, input int c1, input int c2, input int c3);
    int lit [NN];
    lit[0] = c0; lit[1] = c1; lit[2] = c2; lit[3] = c3;
    for (int e = 0; e < NN; e++) begin
      chk({name, "_model"}, cexp[e], lit[e]);
      chk({name, "_dut"}, cwr[e], lit[e]);
    end
  endtask

  initial begin
    mode = M_OFF;
    rc = 0;
    nwr = 0;
    bus.status = 2'b00;
    for (int e = 0; e < NN; e++) begin
      amem[e] = '0;
      bmem[e] = '0;
    end

    // reset values
    repeat (3) @(posedge clock);
    #1;
    chk("rst_c_we", bus.c_we, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_finish", bus.process_finish, 0);
    chk("rst_a_addr", bus.a_addr, 0);
    chk("rst_b_addr", bus.b_addr, 0);
    chk("rst_c_addr", bus.c_addr, 0);
    chk("rst_c_data", bus.c_data, 0);
    reset = 1'b0;

    // idle hold
    mode = M_IDLE;
    repeat (50) @(posedge clock);
    #1;
    mode = M_OFF;

    // identity
    av = '{1, 0, 0, 1};
    bv = '{1, 2, 3, 4};
    do_run();
    chk_c("identity", 1, 2, 3, 4);

    // DONE holds under status 11, leaves on 00
    bus.status = 2'b11;
    repeat (5) begin
      @(posedge clock); #1;
      chk("done_hold_finish", bus.process_finish, 1);
      chk("done_hold_busy", bus.busy, 0);
    end
    bus.status = 2'b00;
    @(posedge clock); #1;
    chk("back_idle_finish", bus.process_finish, 0);
    chk("back_idle_busy", bus.busy, 0);

    // signed
    av = '{-1, 2, 3, -4};
    bv = '{5, -6, 7, 8};
    do_run();
    chk_c("signed", 9, 22, -13, -50);
    raw = bus.c_data;
    chk("signed_hold_bits", raw, 17'h1FFCE);
    chk("signed_hold_addr", bus.c_addr, 3);
    bus.status = 2'b00;
    @(posedge clock);

    // extremes
    av = '{-128, -128, -128, -128};
    bv = '{-128, -128, -128, -128};
    do_run();
    chk_c("extreme", 32768, 32768, 32768, 32768);
    raw = bus.c_data;
    chk("extreme_bits", raw, 17'h08000);
    bus.status = 2'b00;
    @(posedge clock);

    // reset in cycle 4 of a run
    av = '{-1, 2, 3, -4};
    bv = '{5, -6, 7, 8};
    start_run();
    repeat (5) @(posedge clock);
    #1;
    mode = M_OFF;
    reset = 1'b1;
    #1;
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_c_we", bus.c_we, 0);
    chk("midrst_finish", bus.process_finish, 0);
    chk("midrst_c_data", bus.c_data, 0);
    bus.status = 2'b00;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    do_run();
    chk_c("after_rst", 9, 22, -13, -50);
    bus.status = 2'b00;
    @(posedge clock);

    // abort in cycle 2
    av = '{1, 0, 0, 1};
    bv = '{1, 2, 3, 4};
    start_run();
    repeat (3) @(posedge clock);
    #1;
    bus.status = 2'b00;
    @(posedge clock); #1;
    mode = M_QUIET;
    repeat (10) @(posedge clock);
    #1;
    mode = M_OFF;
    chk("abort_writes", nwr, 0);
    chk("abort_busy", bus.busy, 0);
    chk("abort_finish", bus.process_finish, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
